// File: rtl/aes_sbox_sched_pkg.sv
// aes_sbox_sched_pkg
//   Shared definitions for the S-box scheduler: FSM state encoding, grant
//   pointer values, beat-count derivation and byte-slice helpers.
//   Configuration macro: SBOX_PIPE_EN adds the StDrain state.
package aes_sbox_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRunSt = 2'd1,
        StRunKs = 2'd2
`ifdef SBOX_PIPE_EN
        , StDrain = 2'd3
`endif
    } sched_state_e;

    localparam logic GRANT_ST = 1'b0;
    localparam logic GRANT_KS = 1'b1;

    // Beats needed to push n_bytes through n_lanes lanes (rounded up).
    function automatic int unsigned sbox_beats(input int unsigned n_bytes,
                                               input int unsigned n_lanes);
        return (n_bytes + n_lanes - 1) / n_lanes;
    endfunction

    function automatic logic [7:0] byte_of128(input logic [127:0] d, input int unsigned idx);
        logic [3:0] sel;
        sel = 4'(idx);
        return d[8*sel +: 8];
    endfunction

    // Key words have only four bytes; lanes past them see zero.
    function automatic logic [7:0] byte_of32(input logic [31:0] d, input int unsigned idx);
        logic [1:0] sel;
        sel = 2'(idx);
        return (idx < 4) ? d[8*sel +: 8] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox_composite_working.sv
// aes_sbox_composite_working
//   Single AES S-box lane, forward or inverse, purely combinational.
//   Multiplicative inverse is taken as x^254 in GF(2^8) (poly 0x11b),
//   wrapped by the forward or inverse affine map.
// Ports:
//   i_enc_dec  1 = forward S-box, 0 = inverse S-box
//   i_data     input byte
//   o_data     substituted byte
module aes_sbox_composite_working (
    input  logic       i_enc_dec,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128;
        x2   = gf_mul(a, a);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] w_inv_in;
    logic [7:0] w_inv_out;

    assign w_inv_in  = i_enc_dec ? i_data : inv_affine(i_data);
    assign w_inv_out = gf_inv(w_inv_in);
    assign o_data    = i_enc_dec ? fwd_affine(w_inv_out) : w_inv_out;

endmodule

// File: rtl/aes_sbox_lane_array.sv
// aes_sbox_lane_array
//   NUM_SBOX parallel S-box lanes sharing one direction select.
//   Configuration macro: SBOX_PIPE_EN registers the lane outputs (clock and
//   reset ports exist only in that build).
// Ports:
//   i_clk, i_rst_n  clock / sync active-low reset (SBOX_PIPE_EN only)
//   i_enc_dec       1 = forward, 0 = inverse, common to all lanes
//   i_data          lane inputs, lane g = bits [8g+7:8g]
//   o_data          lane outputs, same packing
module aes_sbox_lane_array #(
    parameter int unsigned NUM_SBOX = 4
) (
`ifdef SBOX_PIPE_EN
    input  logic                  i_clk,
    input  logic                  i_rst_n,
`endif
    input  logic                  i_enc_dec,
    input  logic [8*NUM_SBOX-1:0] i_data,
    output logic [8*NUM_SBOX-1:0] o_data
);

    logic [8*NUM_SBOX-1:0] w_sbox_out;

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
        aes_sbox_composite_working u_sbox (
            .i_enc_dec (i_enc_dec),
            .i_data    (i_data[8*g +: 8]),
            .o_data    (w_sbox_out[8*g +: 8])
        );
    end

`ifdef SBOX_PIPE_EN
    logic [8*NUM_SBOX-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_data <= '0;
        else          r_data <= w_sbox_out;
    end

    assign o_data = r_data;
`else
    assign o_data = w_sbox_out;
`endif

endmodule

// File: rtl/aes_sbox_scheduler.sv
// aes_sbox_scheduler
//   Time-shares NUM_SBOX S-box lanes between the round datapath (128-bit
//   SubBytes/InvSubBytes) and key expansion (32-bit forward SubWord).
//   One input buffer and one result register per requester; round-robin
//   grant on contention, decided in StIdle only, jobs never preempted.
//   Configuration macro: SBOX_PIPE_EN inserts a register after the lanes and
//   a StDrain state that writes the final beat (+1 cycle per job).
// Ports:
//   i_clk, i_rst_n                         clock, sync active-low reset
//   i_st_valid/o_st_ready, i_st_data,
//   i_st_enc_dec                           state request (1 = forward)
//   o_st_res_valid/i_st_res_ready,
//   o_st_res_data                          state result
//   i_ks_valid/o_ks_ready, i_ks_word       key-word request
//   o_ks_res_valid/i_ks_res_ready,
//   o_ks_res_word                          SubWord result
module aes_sbox_scheduler
    import aes_sbox_sched_pkg::*;
#(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_st_valid,
    output logic         o_st_ready,
    input  logic [127:0] i_st_data,
    input  logic         i_st_enc_dec,
    output logic         o_st_res_valid,
    input  logic         i_st_res_ready,
    output logic [127:0] o_st_res_data,
    input  logic         i_ks_valid,
    output logic         o_ks_ready,
    input  logic [31:0]  i_ks_word,
    output logic         o_ks_res_valid,
    input  logic         i_ks_res_ready,
    output logic [31:0]  o_ks_res_word
);

    localparam int unsigned ST_BEATS = sbox_beats(16, NUM_SBOX);
    localparam int unsigned KS_BEATS = sbox_beats(4, NUM_SBOX);
    localparam int unsigned CNT_W    = (ST_BEATS > 1) ? $clog2(ST_BEATS) : 1;
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(ST_BEATS - 1);
    localparam logic [CNT_W-1:0] KS_LAST = CNT_W'(KS_BEATS - 1);

    sched_state_e     r_state;
    logic             r_grant;
    logic [CNT_W-1:0] r_beat;
    logic             r_live;   // holds readies low until the cycle after reset
    logic             r_st_full, r_st_enc, r_ks_full;
    logic [127:0]     r_st_buf, r_st_res;
    logic [31:0]      r_ks_buf, r_ks_res;
    logic             r_st_res_valid, r_ks_res_valid;

    logic [8*NUM_SBOX-1:0] w_lane_in, w_lane_out;
    logic                  w_lane_enc;
    logic                  w_wr_en, w_wr_st;
    logic [CNT_W-1:0]      w_wr_beat;

    // Beat k feeds bytes [k*NUM_SBOX +: NUM_SBOX] of the active job.
    always_comb begin
        w_lane_in  = '0;
        w_lane_enc = 1'b1;
        if (r_state == StRunSt) w_lane_enc = r_st_enc;
        for (int unsigned i = 0; i < NUM_SBOX; i++) begin
            if (r_state == StRunSt) begin
                w_lane_in[8*i +: 8] = byte_of128(r_st_buf, 32'(r_beat) * NUM_SBOX + i);
            end else if (r_state == StRunKs) begin
                w_lane_in[8*i +: 8] = byte_of32(r_ks_buf, 32'(r_beat) * NUM_SBOX + i);
            end
        end
    end

    aes_sbox_lane_array #(
        .NUM_SBOX (NUM_SBOX)
    ) u_lanes (
`ifdef SBOX_PIPE_EN
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
`endif
        .i_enc_dec (w_lane_enc),
        .i_data    (w_lane_in),
        .o_data    (w_lane_out)
    );

`ifdef SBOX_PIPE_EN
    // Tags travel alongside the lane register so the write lands one cycle late.
    logic             r_pipe_vld, r_pipe_st;
    logic [CNT_W-1:0] r_pipe_beat;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pipe_vld  <= 1'b0;
            r_pipe_st   <= 1'b0;
            r_pipe_beat <= '0;
        end else begin
            r_pipe_vld  <= (r_state == StRunSt) || (r_state == StRunKs);
            r_pipe_st   <= (r_state == StRunSt);
            r_pipe_beat <= r_beat;
        end
    end

    assign w_wr_en   = r_pipe_vld;
    assign w_wr_st   = r_pipe_st;
    assign w_wr_beat = r_pipe_beat;
`else
    assign w_wr_en   = (r_state == StRunSt) || (r_state == StRunKs);
    assign w_wr_st   = (r_state == StRunSt);
    assign w_wr_beat = r_beat;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_grant        <= GRANT_KS;
            r_beat         <= '0;
            r_live         <= 1'b0;
            r_st_full      <= 1'b0;
            r_st_enc       <= 1'b0;
            r_st_buf       <= '0;
            r_ks_full      <= 1'b0;
            r_ks_buf       <= '0;
            r_st_res       <= '0;
            r_st_res_valid <= 1'b0;
            r_ks_res       <= '0;
            r_ks_res_valid <= 1'b0;
        end else begin
            r_live <= 1'b1;

            if (i_st_valid && o_st_ready) begin
                r_st_full <= 1'b1;
                r_st_buf  <= i_st_data;
                r_st_enc  <= i_st_enc_dec;
            end
            if (i_ks_valid && o_ks_ready) begin
                r_ks_full <= 1'b1;
                r_ks_buf  <= i_ks_word;
            end
            if (r_st_res_valid && i_st_res_ready) r_st_res_valid <= 1'b0;
            if (r_ks_res_valid && i_ks_res_ready) r_ks_res_valid <= 1'b0;

            if (w_wr_en) begin
                for (int unsigned i = 0; i < NUM_SBOX; i++) begin
                    if (w_wr_st) begin
                        r_st_res[8*(32'(w_wr_beat) * NUM_SBOX + i) +: 8] <= w_lane_out[8*i +: 8];
                    end else if (32'(w_wr_beat) * NUM_SBOX + i < 4) begin
                        r_ks_res[8*(32'(w_wr_beat) * NUM_SBOX + i) +: 8] <= w_lane_out[8*i +: 8];
                    end
                end
            end

            case (r_state)
                StIdle: begin
                    if (r_st_full && r_ks_full) begin
                        r_state <= (r_grant == GRANT_ST) ? StRunSt : StRunKs;
                        r_grant <= ~r_grant;
                    end else if (r_st_full) begin
                        r_state <= StRunSt;
                    end else if (r_ks_full) begin
                        r_state <= StRunKs;
                    end
                end
                StRunSt: begin
                    if (r_beat == ST_LAST) begin
                        r_beat <= '0;
`ifdef SBOX_PIPE_EN
                        r_state <= StDrain;
`else
                        r_state        <= StIdle;
                        r_st_full      <= 1'b0;
                        r_st_res_valid <= 1'b1;
`endif
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                StRunKs: begin
                    if (r_beat == KS_LAST) begin
                        r_beat <= '0;
`ifdef SBOX_PIPE_EN
                        r_state <= StDrain;
`else
                        r_state        <= StIdle;
                        r_ks_full      <= 1'b0;
                        r_ks_res_valid <= 1'b1;
`endif
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
`ifdef SBOX_PIPE_EN
                StDrain: begin
                    r_state <= StIdle;
                    if (r_pipe_st) begin
                        r_st_full      <= 1'b0;
                        r_st_res_valid <= 1'b1;
                    end else begin
                        r_ks_full      <= 1'b0;
                        r_ks_res_valid <= 1'b1;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_st_ready     = r_live && !r_st_full && !r_st_res_valid;
    assign o_ks_ready     = r_live && !r_ks_full && !r_ks_res_valid;
    assign o_st_res_valid = r_st_res_valid;
    assign o_st_res_data  = r_st_res;
    assign o_ks_res_valid = r_ks_res_valid;
    assign o_ks_res_word  = r_ks_res;

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// tb_aes_sbox_scheduler
//   Directed, table-driven bench for aes_sbox_scheduler. Expected S-box
//   values are standard AES constants; latencies follow the beat arithmetic
//   (SBOX_PIPE_EN adds one cycle per job).
module tb_aes_sbox_scheduler;

    localparam int unsigned NUM_SBOX = 4;
    localparam int unsigned ST_BEATS = 16 / NUM_SBOX;
    localparam int unsigned KS_BEATS = (4 + NUM_SBOX - 1) / NUM_SBOX;
`ifdef SBOX_PIPE_EN
    localparam int unsigned PIPE_LAT = 1;
`else
    localparam int unsigned PIPE_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_valid = 1'b0, st_ready, st_enc_dec = 1'b1;
    logic [127:0] st_data = '0, st_res_data;
    logic         st_res_valid, st_res_ready = 1'b0;
    logic         ks_valid = 1'b0, ks_ready;
    logic [31:0]  ks_word = '0, ks_res_word;
    logic         ks_res_valid, ks_res_ready = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    aes_sbox_scheduler #(
        .NUM_SBOX (NUM_SBOX)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_st_valid     (st_valid),
        .o_st_ready     (st_ready),
        .i_st_data      (st_data),
        .i_st_enc_dec   (st_enc_dec),
        .o_st_res_valid (st_res_valid),
        .i_st_res_ready (st_res_ready),
        .o_st_res_data  (st_res_data),
        .i_ks_valid     (ks_valid),
        .o_ks_ready     (ks_ready),
        .i_ks_word      (ks_word),
        .o_ks_res_valid (ks_res_valid),
        .i_ks_res_ready (ks_res_ready),
        .o_ks_res_word  (ks_res_word)
    );

    typedef struct {
        string        name;
        logic         is_ks;
        logic         enc;
        logic [127:0] din;
        logic [127:0] expd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expd);
        n_total++;
        if (act === expd) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expd);
    endtask

    task automatic wait_ready(input logic is_ks, output bit ok);
        int n = 0;
        ok = 1'b1;
        while ((is_ks ? ks_ready : st_ready) !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_job(input vec_t v);
        bit ok;
        int lat;
        logic [127:0] got;
        wait_ready(v.is_ks, ok);
        check({v.name, " ready"}, ok, 1'b1);
        if (!ok) return;
        if (v.is_ks) begin
            ks_valid = 1'b1;
            ks_word  = v.din[31:0];
        end else begin
            st_valid   = 1'b1;
            st_data    = v.din;
            st_enc_dec = v.enc;
        end
        @(negedge clk);
        st_valid = 1'b0;
        ks_valid = 1'b0;
        check({v.name, " busy"}, v.is_ks ? ks_ready : st_ready, 1'b0);
        lat = 0;
        while ((v.is_ks ? ks_res_valid : st_res_valid) !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got = v.is_ks ? {96'h0, ks_res_word} : st_res_data;
        check({v.name, " data"}, got, v.expd);
        check({v.name, " latency"}, lat,
              (v.is_ks ? KS_BEATS : ST_BEATS) + 1 + PIPE_LAT);
        if (v.is_ks) ks_res_ready = 1'b1;
        else         st_res_ready = 1'b1;
        @(negedge clk);
        ks_res_ready = 1'b0;
        st_res_ready = 1'b0;
        check({v.name, " valid clear"}, v.is_ks ? ks_res_valid : st_res_valid, 1'b0);
    endtask

    task automatic contention(input string name, input bit ks_first,
                              input logic [127:0] st_in, input logic [127:0] st_exp,
                              input logic [31:0] ks_in, input logic [31:0] ks_exp);
        bit ok_s, ok_k;
        int st_c = -1;
        int ks_c = -1;
        int first_c, second_c;
        wait_ready(1'b0, ok_s);
        wait_ready(1'b1, ok_k);
        check({name, " ready"}, {ok_s, ok_k}, 2'b11);
        st_valid   = 1'b1;
        st_data    = st_in;
        st_enc_dec = 1'b1;
        ks_valid   = 1'b1;
        ks_word    = ks_in;
        @(negedge clk);
        st_valid = 1'b0;
        ks_valid = 1'b0;
        for (int c = 0; c < 200 && (st_c < 0 || ks_c < 0); c++) begin
            if (st_c < 0 && st_res_valid === 1'b1) st_c = c;
            if (ks_c < 0 && ks_res_valid === 1'b1) ks_c = c;
            if (st_c < 0 || ks_c < 0) @(negedge clk);
        end
        first_c  = ks_first ? ks_c : st_c;
        second_c = ks_first ? st_c : ks_c;
        check({name, " first done"}, first_c,
              (ks_first ? KS_BEATS : ST_BEATS) + 1 + PIPE_LAT);
        check({name, " second done"}, second_c, KS_BEATS + ST_BEATS + 2 + 2 * PIPE_LAT);
        check({name, " st data"}, st_res_data, st_exp);
        check({name, " ks data"}, ks_res_word, ks_exp);
        st_res_ready = 1'b1;
        ks_res_ready = 1'b1;
        @(negedge clk);
        st_res_ready = 1'b0;
        ks_res_ready = 1'b0;
        check({name, " valids clear"}, {st_res_valid, ks_res_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int quiet;
        bit ks_seen;
        logic [31:0] ks_got;
        bit ok;

        vecs[0] = '{"fwd zero",  1'b0, 1'b1, 128'h0, {16{8'h63}}};
        vecs[1] = '{"inv 63s",   1'b0, 1'b0, {16{8'h63}}, 128'h0};
        vecs[2] = '{"fwd 53s",   1'b0, 1'b1, {16{8'h53}}, {16{8'hed}}};
        vecs[3] = '{"fwd ramp",  1'b0, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100,
                    128'h76abd7fe2b670130c56f6bf27b777c63};
        vecs[4] = '{"inv ramp",  1'b0, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63,
                    128'h0f0e0d0c0b0a09080706050403020100};
        vecs[5] = '{"ks 000000ff", 1'b1, 1'b1, 128'h000000ff, 128'h63636316};
        vecs[6] = '{"ks aa00ff53", 1'b1, 1'b1, 128'haa00ff53, 128'hac6316ed};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset flags", {st_ready, ks_ready, st_res_valid, ks_res_valid}, 4'b0000);
        check("reset st data", st_res_data, 128'h0);
        check("reset ks word", ks_res_word, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("readies after reset", {st_ready, ks_ready}, 2'b11);

        // Grant pointer starts at KS, then flips to ST
        contention("contend1", 1'b1, 128'h0, {16{8'h63}}, 32'h000000ff, 32'h63636316);
        contention("contend2", 1'b0, {16{8'h53}}, {16{8'hed}}, 32'h03020100, 32'h7b777c63);

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Backpressure on the state result while a key job runs
        wait_ready(1'b0, ok);
        st_valid   = 1'b1;
        st_data    = 128'h0f0e0d0c0b0a09080706050403020100;
        st_enc_dec = 1'b1;
        @(negedge clk);
        st_valid = 1'b0;
        for (int c = 0; c < 200 && st_res_valid !== 1'b1; c++) @(negedge clk);
        check("bp ks_ready", ks_ready, 1'b1);
        ks_valid = 1'b1;
        ks_word  = 32'haa00ff53;
        bad      = 0;
        ks_seen  = 1'b0;
        ks_got   = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ks_valid     = 1'b0;
            ks_res_ready = 1'b0;
            if (st_res_valid !== 1'b1 || st_ready !== 1'b0 ||
                st_res_data !== 128'h76abd7fe2b670130c56f6bf27b777c63) bad++;
            if (ks_res_valid === 1'b1 && !ks_seen) begin
                ks_seen      = 1'b1;
                ks_got       = ks_res_word;
                ks_res_ready = 1'b1;
            end
        end
        @(negedge clk);
        ks_res_ready = 1'b0;
        check("bp stall violations", bad, 0);
        check("bp ks completed", ks_seen, 1'b1);
        check("bp ks word", ks_got, 32'hac6316ed);
        st_res_ready = 1'b1;
        @(negedge clk);
        st_res_ready = 1'b0;
        check("bp st released", st_res_valid, 1'b0);

        // Reset in the middle of a state job
        wait_ready(1'b0, ok);
        st_valid   = 1'b1;
        st_data    = {16{8'h53}};
        st_enc_dec = 1'b1;
        @(negedge clk);
        st_valid = 1'b0;
        @(negedge clk);
        check("midrun busy", st_ready, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun reset flags", {st_ready, ks_ready, st_res_valid, ks_res_valid}, 4'b0000);
        check("midrun reset st data", st_res_data, 128'h0);
        check("midrun reset ks word", ks_res_word, 32'h0);
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (st_res_valid === 1'b1 || ks_res_valid === 1'b1) quiet++;
        end
        check("midrun no result", quiet, 0);
        run_job(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
